dmem_responder: RTL and testbench

Word-organised data memory that acts as the responder on the processor's load/store request channel. It accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, commits stores with byte enables, and returns load data over a second valid/ready handshake. It also drives the five debug taps m0, m4, m8, m12 and m16 that the processor-level bench watches.

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory responding on a valid/ready load/store channel.
// One request in flight, fixed wait states, byte-enabled stores, debug taps.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                : response channel
//   m0, m4, m8, m12, m16                                 : words 0..4
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] m0,
    output logic [31:0] m4,
    output logic [31:0] m8,
    output logic [31:0] m12,
    output logic [31:0] m16
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        started_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_err;
    logic [AW-1:0] e_idx;

    assign req_ready = started_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // With zero latency the commit happens on the accepting edge, so the
    // live request inputs are used instead of the captured copy.
    always_comb begin
        e_we    = we_q;
        e_addr  = addr_q;
        e_wdata = wdata_q;
        e_be    = be_q;
        if (state_q == IDLE) begin
            e_we    = req_we;
            e_addr  = req_addr;
            e_wdata = req_wdata;
            e_be    = req_be;
        end
        e_err = (e_addr[1:0] != 2'b00) || (e_addr[31:2] >= 30'(DEPTH));
        e_idx = e_addr[AW+1:2];
        enter_resp = ((state_q == IDLE) && accept && (LATENCY == 0))
                  || ((state_q == WAIT) && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            started_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            started_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= e_err;
                rsp_rdata_q <= (e_err || e_we) ? 32'd0 : mem_q[e_idx];
                if (!e_err && e_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (e_be[b]) begin
                            mem_q[e_idx][8*b +: 8] <= e_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign m0  = mem_q[0];
    assign m4  = mem_q[1];
    assign m8  = mem_q[2];
    assign m12 = mem_q[3];
    assign m16 = mem_q[4];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 0, 5)
// driven with directed and random load/store traffic against a word model.
module tb_dmem_responder;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic [31:0] m0 [3];
    logic [31:0] m4 [3];
    logic [31:0] m8 [3];
    logic [31:0] m12 [3];
    logic [31:0] m16 [3];

    exp_t        exp_q [3][$];
    logic [31:0] mem_m [3][32];
    logic [31:0] last_rd  [3];
    logic        last_err [3];
    bit          rnd_rdy  [3];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : 5;
        dmem_responder #(.DEPTH(32), .LATENCY(L)) u_dut (
            .clk       (clk),
            .rst       (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .m0        (m0[g]),
            .m4        (m4[g]),
            .m8        (m8[g]),
            .m12       (m12[g]),
            .m16       (m16[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 5;
    endfunction

    function automatic logic [31:0] tap(input int d, input int i);
        case (i)
            0: return m0[d];
            1: return m4[d];
            2: return m8[d];
            3: return m12[d];
            default: return m16[d];
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req,
                     $time);
        end
    endtask

    // Reference: byte-addressed word memory with alignment/range errors.
    function automatic exp_t model_op(input int d, input bit we,
                                      input logic [31:0] a,
                                      input logic [31:0] wd,
                                      input logic [3:0] be);
        exp_t e;
        longint unsigned widx = a / 4;
        e.err   = (a % 4 != 0) || (widx >= 32);
        e.rdata = 32'd0;
        e.due   = 0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b])
                        mem_m[d][widx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.rdata = mem_m[d][widx];
            end
        end
        return e;
    endfunction

    task automatic txn(input int d, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input bit ex);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout inst=%0d waited=%0d limit=100",
                     d, n);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        if (ex) begin
            e     = model_op(d, we, a, wd, be);
            e.due = cyc + lat_of(d);
            exp_q[d].push_back(e);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((exp_q[d].size() != 0 || rsp_valid[d]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL idle_timeout inst=%0d waited=%0d limit=300", d, n);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++)
            if (rnd_rdy[d]) rsp_ready[d] = 1'($urandom_range(0, 1));
    end

    for (genvar g = 0; g < 3; g++) begin : gen_mon
        bit          seen = 0;
        bit          take = 0;
        logic [31:0] h_rd;
        logic        h_err;
        exp_t        e;
        always @(negedge clk) begin
            if (!rst_n[g]) begin
                seen = 0;
                take = 0;
            end else begin
                if (take) begin
                    chk("valid_drop", 32'(rsp_valid[g]), 32'd0);
                    chk("ready_after_take", 32'(req_ready[g]), 32'd1);
                end
                if (rsp_valid[g]) begin
                    chk("ready_busy", 32'(req_ready[g]), 32'd0);
                    if (!seen) begin
                        if (exp_q[g].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp inst=%0d rdata=%h required=none",
                                     g, rsp_rdata[g]);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk("rsp_rdata", rsp_rdata[g], e.rdata);
                            chk("rsp_err", 32'(rsp_err[g]), 32'(e.err));
                            chk("rsp_latency", 32'(cyc), 32'(e.due));
                            for (int i = 0; i < 5; i++)
                                chk("tap", tap(g, i), mem_m[g][i]);
                        end
                        seen  = 1;
                        h_rd  = rsp_rdata[g];
                        h_err = rsp_err[g];
                        last_rd[g]  = rsp_rdata[g];
                        last_err[g] = rsp_err[g];
                    end else begin
                        chk("hold_rdata", rsp_rdata[g], h_rd);
                        chk("hold_err", 32'(rsp_err[g]), 32'(h_err));
                    end
                    take = rsp_ready[g];
                end else begin
                    seen = 0;
                    take = 0;
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
            rnd_rdy[d]   = 1'b0;
            for (int i = 0; i < 32; i++) mem_m[d][i] = '0;
        end

        // Reset value and release behaviour.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
                chk("rst_ready", 32'(req_ready[d]), 32'd0);
                for (int i = 0; i < 5; i++) chk("rst_tap", tap(d, i), 32'd0);
            end
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            chk("ready_pre_edge", 32'(req_ready[d]), 32'd0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("ready_post_edge", 32'(req_ready[d]), 32'd1);
            chk("valid_post_rst", 32'(rsp_valid[d]), 32'd0);
        end

        // Store then load, LATENCY=2.
        txn(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 1);
        wait_idle(0);
        chk("m8_store", m8[0], 32'hDEADBEEF);
        chk("store_err", 32'(last_err[0]), 32'd0);
        txn(0, 0, 32'h8, 32'h0, 4'h0, 1);
        wait_idle(0);
        chk("load_m8", last_rd[0], 32'hDEADBEEF);

        // Byte enables.
        txn(0, 1, 32'h4, 32'h12345678, 4'hF, 1);
        txn(0, 1, 32'h4, 32'hAABBCCDD, 4'b0101, 1);
        wait_idle(0);
        chk("m4_be0101", m4[0], 32'h12BB56DD);
        txn(0, 1, 32'h4, 32'hFFFFFFFF, 4'b0000, 1);
        wait_idle(0);
        chk("m4_be0000", m4[0], 32'h12BB56DD);
        chk("be0000_err", 32'(last_err[0]), 32'd0);

        // Errors.
        txn(0, 0, 32'h6, 32'h0, 4'h0, 1);
        wait_idle(0);
        chk("misalign_err", 32'(last_err[0]), 32'd1);
        chk("misalign_rdata", last_rd[0], 32'd0);
        txn(0, 1, 32'h80, 32'hCAFEF00D, 4'hF, 1);
        wait_idle(0);
        chk("range_err", 32'(last_err[0]), 32'd1);
        chk("range_m0", m0[0], 32'd0);
        chk("range_m4", m4[0], 32'h12BB56DD);
        chk("range_m8", m8[0], 32'hDEADBEEF);
        chk("range_m12", m12[0], 32'd0);
        chk("range_m16", m16[0], 32'd0);

        // Backpressure, LATENCY=0.
        txn(1, 1, 32'h4, 32'h0BADF00D, 4'hF, 1);
        wait_idle(1);
        rsp_ready[1] = 1'b0;
        txn(1, 0, 32'h4, 32'h0, 4'h0, 1);
        chk("lat0_valid", 32'(rsp_valid[1]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        wait_idle(1);
        chk("bp_load", last_rd[1], 32'h0BADF00D);

        // Reset during WAIT, LATENCY=5.
        txn(2, 1, 32'h10, 32'h55, 4'hF, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        exp_q[2].delete();
        for (int i = 0; i < 32; i++) mem_m[2][i] = '0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_m16", m16[2], 32'd0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(rsp_valid[2]), 32'd0);
        end
        chk("post_rst_m16", m16[2], 32'd0);

        // Random traffic on every instance with random response backpressure.
        for (int d = 0; d < 3; d++) begin
            rnd_rdy[d] = 1'b1;
            for (int k = 0; k < 40; k++) begin
                logic [31:0] a;
                int          sel = int'($urandom_range(0, 9));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (sel < 7)      a = 32'($urandom_range(0, 7)) * 4;
                else if (sel < 9) a = 32'($urandom_range(32, 40)) * 4;
                else              a = 32'($urandom_range(0, 31)) * 4 +
                                      32'($urandom_range(1, 3));
                txn(d, 1'($urandom_range(0, 1)), a, $urandom,
                    4'($urandom_range(0, 15)), 1);
            end
            wait_idle(d);
            rnd_rdy[d]   = 1'b0;
            rsp_ready[d] = 1'b1;
        end

        for (int d = 0; d < 3; d++)
            chk("queue_empty", 32'(exp_q[d].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
